// File: rtl/matrix_mac_sequencer_if.sv
// Stream bundle for the matrix MAC sequencer: element input, C-element output and a busy flag.
interface matrix_mac_sequencer_if #(
   parameter int DW = 8,
   parameter int OW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/matrix_mac_sequencer.sv
// Loads A then B row-major, computes C = A x B with one MAC per cycle (N^3 cycles), streams C out.
// First out_valid N^3+1 cycles after the last B accept; output register holds while out_ready=0.
module matrix_mac_sequencer #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int OW = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   matrix_mac_sequencer_if.slave  bus
);
   localparam int LG = $clog2(N);
   localparam int IW = 2 * LG;
   localparam int CW = 3 * LG;
   localparam int AW = 2 * DW + LG;
   localparam int NN = N * N;
   localparam logic [IW-1:0] LAST_IDX = '1;
   localparam logic [CW-1:0] LAST_CNT = '1;
   localparam logic [LG-1:0] LAST_K   = '1;

   typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [OW-1:0] out_data_q, out_data_d;
   logic          out_last_q, out_last_d;

   logic [DW-1:0] a_mem_q [NN];
   logic [DW-1:0] b_mem_q [NN];
   logic [OW-1:0] c_mem_q [NN];

   logic          a_we, b_we, c_we;
   logic          in_xfer, out_xfer;
   logic [LG-1:0] i_idx, j_idx, k_idx;
   logic [DW-1:0] a_rd, b_rd;
   logic [2*DW-1:0] prod;
   logic [AW-1:0]   acc_base, mac_sum;
   logic [AW+OW-1:0] acc_ext;
   logic [OW-1:0]  c_wdat;
   logic [IW-1:0]  idx_nxt;

   // The flat compute counter is {i, j, k} with k fastest.
   assign i_idx = cnt_q[CW-1 -: LG];
   assign j_idx = cnt_q[IW-1 -: LG];
   assign k_idx = cnt_q[LG-1:0];

   assign a_rd     = a_mem_q[{i_idx, k_idx}];
   assign b_rd     = b_mem_q[{k_idx, j_idx}];
   assign prod     = {{DW{1'b0}}, a_rd} * {{DW{1'b0}}, b_rd};
   assign acc_base = (k_idx == '0) ? '0 : acc_q;
   assign mac_sum  = {{LG{1'b0}}, prod} + acc_base;
   assign acc_ext  = {{OW{1'b0}}, mac_sum};
   assign c_wdat   = acc_ext[OW-1:0];
   assign idx_nxt  = idx_q + 1'b1;

   assign in_xfer  = bus.in_valid && in_ready_q;
   assign out_xfer = out_valid_q && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      a_we        = 1'b0;
      b_we        = 1'b0;
      c_we        = 1'b0;

      case (state_q)
         LOAD_A: begin
            if (in_xfer) begin
               a_we  = 1'b1;
               idx_d = idx_nxt;
               if (idx_q == LAST_IDX) state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (in_xfer) begin
               b_we  = 1'b1;
               idx_d = idx_nxt;
               if (idx_q == LAST_IDX) state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            acc_d = mac_sum;
            cnt_d = cnt_q + 1'b1;
            c_we  = (k_idx == LAST_K);
            if (cnt_q == LAST_CNT) state_d = DRAIN;
         end
         DRAIN: begin
            // One fill cycle loads C[0] into the output register before the first offer.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = c_mem_q[idx_q];
               out_last_d  = (idx_q == LAST_IDX);
            end else if (out_xfer) begin
               if (out_last_q) begin
                  state_d     = LOAD_A;
                  out_valid_d = 1'b0;
                  out_data_d  = '0;
                  out_last_d  = 1'b0;
                  idx_d       = '0;
               end else begin
                  idx_d      = idx_nxt;
                  out_data_d = c_mem_q[idx_nxt];
                  out_last_d = (idx_nxt == LAST_IDX);
               end
            end
         end
         default: state_d = LOAD_A;
      endcase

      in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD_A;
         idx_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Matrix storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (a_we) a_mem_q[idx_q] <= bus.in_data;
      if (b_we) b_mem_q[idx_q] <= bus.in_data;
      if (c_we) c_mem_q[{i_idx, j_idx}] <= c_wdat;
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = (state_q == COMPUTE) || (state_q == DRAIN);
endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Randomised bench for matrix_mac_sequencer against a plain matrix-product model.
module tb_matrix_mac_sequencer;
   localparam int N = 4, DW = 8, OW = 16, NN = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   matrix_mac_sequencer_if #(.DW(DW), .OW(OW)) bus ();
   matrix_mac_sequencer #(.N(N), .DW(DW), .OW(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0, errs = 0, cyc = 0;
   int ma [NN];
   int mb [NN];
   int exp_c [NN];
   int job_id = 0, lastb_job = 0, lastb_cyc = 0;
   bit rnd_ordy = 1'b0, stall_req = 1'b0;

   int mon_job = 0, out_idx = 0, done_job = 0, tot_xfer = 0;
   bit in_drain = 1'b0, lat_pending = 1'b0, prev_stall = 1'b0, last_done = 1'b0;
   logic [OW-1:0] prev_dat;
   logic prev_last;

   int  stall_left = 0;
   bit  stall_taken = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // out_ready driver: optional random backpressure plus one forced 5-cycle stall on request.
   always @(posedge clk) begin
      #1;
      if (stall_req && !stall_taken) begin
         stall_left  = 5;
         stall_taken = 1'b1;
      end
      if (!stall_req) stall_taken = 1'b0;
      if (stall_left > 0) begin
         bus.out_ready = 1'b0;
         stall_left--;
      end else begin
         bus.out_ready = rnd_ordy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Single compare process: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_drain = 1'b0; lat_pending = 1'b0; prev_stall = 1'b0; last_done = 1'b0;
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_out_last", bus.out_last, 0);
         chk("rst_busy", bus.busy, 0);
      end else begin
         if (last_done) begin
            chk("in_ready_after_last", bus.in_ready, 1);
            chk("busy_after_last", bus.busy, 0);
            last_done = 1'b0;
         end
         if (lastb_job != mon_job) begin
            mon_job = lastb_job; in_drain = 1'b1; out_idx = 0; lat_pending = 1'b1;
         end
         if (in_drain) begin
            chk("in_ready_while_busy", bus.in_ready, 0);
            chk("busy", bus.busy, 1);
         end
         if (bus.out_valid) begin
            if (!in_drain || out_idx >= NN) begin
               chk("stray_out_valid", bus.out_valid, 0);
            end else begin
               if (lat_pending) begin
                  chk("latency", cyc - lastb_cyc, N * N * N + 1);
                  lat_pending = 1'b0;
               end
               if (prev_stall) begin
                  chk("stall_hold_data", bus.out_data, prev_dat);
                  chk("stall_hold_last", bus.out_last, prev_last);
               end
               chk("out_data", bus.out_data, exp_c[out_idx]);
               chk("out_last", bus.out_last, (out_idx == NN - 1) ? 1 : 0);
               if (bus.out_ready) begin
                  tot_xfer++;
                  if (out_idx == NN - 1) begin
                     in_drain = 1'b0; done_job = mon_job; last_done = 1'b1;
                  end
                  out_idx++;
                  prev_stall = 1'b0;
               end else begin
                  prev_stall = 1'b1; prev_dat = bus.out_data; prev_last = bus.out_last;
               end
            end
         end else begin
            if (in_drain && !lat_pending) chk("out_valid_dropped", bus.out_valid, 1);
            prev_stall = 1'b0;
         end
      end
   end

   task automatic build_model();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            longint s = 0;
            for (int k = 0; k < N; k++) s += longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
            exp_c[i*N+j] = int'(s % 65536);
         end
   endtask

   task automatic send_job(input int gap_pct);
      job_id++;
      for (int e = 0; e < 2 * NN; e++) begin
         int w = 0;
         while ($urandom_range(0, 99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = (e < NN) ? 8'(ma[e]) : 8'(mb[e - NN]);
         forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
            if (w > 300) break;
         end
         if (w > 300) begin
            chk("in_ready_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         if (e == 2 * NN - 1) begin
            lastb_cyc = cyc;
            lastb_job = job_id;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_job(input int gap_pct, input bit do_stall);
      int x0 = tot_xfer;
      int w = 0;
      build_model();
      send_job(gap_pct);
      if (do_stall) begin
         while (tot_xfer < x0 + 7 && w < 400) begin @(posedge clk); w++; end
         stall_req = 1'b1;
         repeat (8) @(posedge clk);
         stall_req = 1'b0;
      end
      w = 0;
      while (done_job != job_id && w < 600) begin @(posedge clk); w++; end
      chk("job_done", done_job, job_id);
      @(posedge clk); @(posedge clk); #1;
      chk("xfer_count", tot_xfer - x0, NN);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // A = 1..16, B = identity, in_valid held high.
      for (int e = 0; e < NN; e++) begin ma[e] = e + 1; mb[e] = (e / N == e % N) ? 1 : 0; end
      build_model();
      chk("model_ident_c0", exp_c[0], 1);
      chk("model_ident_c15", exp_c[15], 16);
      run_job(0, 1'b0);

      // A = B = 1..16.
      for (int e = 0; e < NN; e++) begin ma[e] = e + 1; mb[e] = e + 1; end
      build_model();
      chk("model_c00", exp_c[0], 90);
      chk("model_c13", exp_c[7], 280);
      chk("model_c22", exp_c[10], 398);
      chk("model_c33", exp_c[15], 600);
      run_job(0, 1'b0);

      // All 255: 4*255*255 = 260100, truncated to 16 bits.
      for (int e = 0; e < NN; e++) begin ma[e] = 255; mb[e] = 255; end
      build_model();
      chk("model_sat", exp_c[5], 63492);
      run_job(0, 1'b0);

      // Case 2 with random input gaps and a 5-cycle sink stall mid-drain.
      for (int e = 0; e < NN; e++) begin ma[e] = e + 1; mb[e] = e + 1; end
      run_job(40, 1'b1);

      // Reset pulsed during COMPUTE, then identity job again.
      for (int e = 0; e < NN; e++) begin ma[e] = e + 1; mb[e] = (e / N == e % N) ? 1 : 0; end
      build_model();
      send_job(0);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (90) @(posedge clk);
      #1;
      chk("no_output_after_abort", done_job, job_id - 1);
      run_job(0, 1'b0);

      // Random matrices, random gaps, random backpressure.
      rnd_ordy = 1'b1;
      for (int t = 0; t < 6; t++) begin
         for (int e = 0; e < NN; e++) begin
            ma[e] = int'($urandom_range(0, 255));
            mb[e] = int'($urandom_range(0, 255));
         end
         run_job(30, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
